int_ctrl: RTL

- Interrupt controller in front of the coprocessor-0 exception unit.
- Collects N external interrupt lines into a pending register with per-line masking. Picks one winner by fixed priority and drives the single external-interrupt request into cop0.
- Holds the request until cop0 takes the exception, tracks the handler until ERET, and keeps synchronous exceptions (overflow, wrong address) ahead of external interrupts.

---
 rtl/int_ctrl_pkg.sv | 23 ++
 rtl/int_ctrl_if.sv | 31 +++
 rtl/int_ctrl_prio_enc.sv | 19 +
 rtl/int_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and cop0 constants for the interrupt controller.
package int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   localparam int COP0_STATUS = 12;
   localparam int COP0_CAUSE  = 13;
   localparam int COP0_EPC    = 14;

   localparam int CAUSE_EXT  = 0;
   localparam int CAUSE_ADDR = 1;
   localparam int CAUSE_OVF  = 2;

   // Synchronous exceptions always outrank an external interrupt.
   function automatic logic sync_exc(input logic ovf, input logic wrong_addr);
      return ovf | wrong_addr;
   endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bus between the pipeline/cop0 side (master) and the interrupt controller (slave).
interface int_ctrl_if #(
   parameter int N_IRQ = 8,
   parameter int IDW   = 3
);
   logic [N_IRQ-1:0] i_irq;
   logic [N_IRQ-1:0] i_mask;
   logic             i_int_en;
   logic             i_overflow;
   logic             i_wrong_addr;
   logic             i_ack;
   logic             i_eret;
   logic [N_IRQ-1:0] i_clr;
   logic             o_ext_int;
   logic [IDW-1:0]   o_irq_id;
   logic [N_IRQ-1:0] o_pending;
   logic             o_busy;
   logic             o_taken;

   modport master (
      output i_irq, i_mask, i_int_en, i_overflow, i_wrong_addr,
             i_ack, i_eret, i_clr,
      input  o_ext_int, o_irq_id, o_pending, o_busy, o_taken
   );

   modport slave (
      input  i_irq, i_mask, i_int_en, i_overflow, i_wrong_addr,
             i_ack, i_eret, i_clr,
      output o_ext_int, o_irq_id, o_pending, o_busy, o_taken
   );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module int_ctrl_prio_enc #(
   parameter int N   = 8,
   parameter int IDW = 3
) (
   input  logic [N-1:0]   i_req,
   output logic           o_valid,
   output logic [IDW-1:0] o_id
);

   always_comb begin
      o_valid = |i_req;
      o_id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) o_id = IDW'(i);
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller ahead of cop0: edge capture, masking, priority, handler tracking.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on the raw interrupt lines.
//
//   state   | meaning
//   IDLE    | no request outstanding, looking for an eligible line
//   REQ     | o_ext_int raised for the frozen id, waiting for cop0 to take it
//   SERVICE | exception handler running, waiting for ERET
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int N_IRQ = 8,
   parameter int IDW   = 3
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   int_ctrl_if.slave bus
);

   logic [N_IRQ-1:0] irq_s;
   logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] rise, elig, sel_vec, acc_vec;
   state_e           state_q, state_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             ext_int_q, busy_q, taken_q;
   logic             accept, exc, elig_id;
   logic             win_valid;
   logic [IDW-1:0]   win_id;

`ifdef IRQ_SYNC_EN
   logic [N_IRQ-1:0] meta_q, meta_d, sync_q, sync_d;

   always_comb begin
      meta_d = bus.i_irq;
      sync_d = meta_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign irq_s = sync_q;
`else
   assign irq_s = bus.i_irq;
`endif

   // Mask gates requesting only; capture sees every line.
   assign rise = irq_s & ~irq_prev_q;
   assign elig = pend_q & bus.i_mask;
   assign exc  = sync_exc(bus.i_overflow, bus.i_wrong_addr);

   int_ctrl_prio_enc #(.N(N_IRQ), .IDW(IDW)) u_prio (
      .i_req   (elig),
      .o_valid (win_valid),
      .o_id    (win_id)
   );

   always_comb begin
      sel_vec = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         sel_vec[i] = (id_q == IDW'(i));
      end
      elig_id = |(elig & sel_vec);
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      accept     = 1'b0;
      irq_prev_d = irq_s;
      case (state_q)
         IDLE: begin
            if (bus.i_ack) begin
               state_d = SERVICE;
            end else if (bus.i_int_en && win_valid && !exc) begin
               state_d = REQ;
               id_d    = win_id;
            end
         end
         REQ: begin
            if (bus.i_ack) begin
               state_d = SERVICE;
               accept  = !exc;
            end else if (!bus.i_int_en || !elig_id) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (bus.i_eret) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      acc_vec = accept ? sel_vec : '0;
      // A new edge wins over a clear landing in the same cycle.
      pend_d  = (pend_q & ~(bus.i_clr | acc_vec)) | rise;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         id_q       <= '0;
         pend_q     <= '0;
         irq_prev_q <= '0;
         ext_int_q  <= 1'b0;
         busy_q     <= 1'b0;
         taken_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         pend_q     <= pend_d;
         irq_prev_q <= irq_prev_d;
         ext_int_q  <= (state_d == REQ);
         busy_q     <= (state_d == SERVICE);
         taken_q    <= accept;
      end
   end

   assign bus.o_ext_int = ext_int_q;
   assign bus.o_irq_id  = id_q;
   assign bus.o_pending = pend_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_taken   = taken_q;

endmodule
